// File: rtl/periph_bus_arbiter_if.sv
// Bundle of both master request ports and the shared peripheral slave port.
// The arbiter connects through the slave modport; a requester-side model uses master.
interface periph_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              m0_req_i;
    logic              m0_wen_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_data_i;
    logic [MASK_W-1:0] m0_wmask_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o;

    logic              m1_req_i;
    logic              m1_wen_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_data_i;
    logic [MASK_W-1:0] m1_wmask_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [DATA_W-1:0] m1_rdata_o;

    logic              csb_o;
    logic              wen_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] data_o;
    logic [MASK_W-1:0] wmask_o;
    logic [DATA_W-1:0] rdata_i;

    modport slave (
        input  m0_req_i, m0_wen_i, m0_addr_i, m0_data_i, m0_wmask_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_wen_i, m1_addr_i, m1_data_i, m1_wmask_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output csb_o, wen_o, addr_o, data_o, wmask_o,
        input  rdata_i
    );

    modport master (
        output m0_req_i, m0_wen_i, m0_addr_i, m0_data_i, m0_wmask_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_wen_i, m1_addr_i, m1_data_i, m1_wmask_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  csb_o, wen_o, addr_o, data_o, wmask_o,
        output rdata_i
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the single-ported peripheral bus, one-cycle read latency.
// Define PARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed m0 priority.
module periph_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    periph_bus_arbiter_if.slave  bus
);
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] wmask;
    } acc_t;

    state_t     r_state, w_state_nxt;
    acc_t       r_acc, w_acc_nxt;
    acc_t       w_m0_acc, w_m1_acc;
    logic       r_csb, w_csb_nxt;
    logic       r_wen, w_wen_nxt;
    logic [1:0] r_gnt, w_gnt_nxt;
    logic [1:0] r_rvalid, w_rvalid_nxt;
    logic       r_owner, w_owner_nxt;
    logic       r_last_owner, w_last_owner_nxt;
    logic       w_any_req;
    logic       w_tie_pick;
    logic       w_winner;

    assign w_m0_acc  = '{addr: bus.m0_addr_i, data: bus.m0_data_i, wmask: bus.m0_wmask_i};
    assign w_m1_acc  = '{addr: bus.m1_addr_i, data: bus.m1_data_i, wmask: bus.m1_wmask_i};
    assign w_any_req = bus.m0_req_i | bus.m1_req_i;

`ifdef PARB_ROUND_ROBIN_EN
    assign w_tie_pick = ~r_last_owner;
`else
    assign w_tie_pick = 1'b0;
`endif

    // A lone requester wins outright; only a tie consults the tie-break pick.
    assign w_winner = (bus.m0_req_i & bus.m1_req_i) ? w_tie_pick : bus.m1_req_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_csb        <= 1'b1;
            r_wen        <= 1'b1;
            r_gnt        <= '0;
            r_rvalid     <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_csb        <= w_csb_nxt;
            r_wen        <= w_wen_nxt;
            r_gnt        <= w_gnt_nxt;
            r_rvalid     <= w_rvalid_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // Next state and next registered outputs; strobes idle high unless entering ACCESS.
    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_csb_nxt        = 1'b1;
        w_wen_nxt        = 1'b1;
        w_gnt_nxt        = '0;
        w_rvalid_nxt     = '0;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt      = ACCESS;
                    w_acc_nxt        = w_winner ? w_m1_acc : w_m0_acc;
                    w_wen_nxt        = w_winner ? bus.m1_wen_i : bus.m0_wen_i;
                    w_csb_nxt        = 1'b0;
                    w_gnt_nxt        = w_winner ? 2'b10 : 2'b01;
                    w_owner_nxt      = w_winner;
                    w_last_owner_nxt = w_winner;
                end
            end
            ACCESS: begin
                if (r_wen) begin
                    w_state_nxt  = RESP;
                    w_rvalid_nxt = r_owner ? 2'b10 : 2'b01;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.csb_o   = r_csb;
    assign bus.wen_o   = r_wen;
    assign bus.addr_o  = r_acc.addr;
    assign bus.data_o  = r_acc.data;
    assign bus.wmask_o = r_acc.wmask;

    assign bus.m0_gnt_o    = r_gnt[0];
    assign bus.m1_gnt_o    = r_gnt[1];
    assign bus.m0_rvalid_o = r_rvalid[0];
    assign bus.m1_rvalid_o = r_rvalid[1];

    // Read data is passed straight through from the slave during the owner's RESP cycle.
    assign bus.m0_rdata_o = r_rvalid[0] ? bus.rdata_i : '0;
    assign bus.m1_rdata_o = r_rvalid[1] ? bus.rdata_i : '0;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized bench for periph_bus_arbiter against a transaction-level timing model.
module tb_periph_bus_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;

    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    periph_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    periph_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Master-side stimulus state, one entry per master
    bit              req   [2];
    bit              wen   [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] data  [2];
    logic [MASK_W-1:0] mask  [2];

    // Reference model: one transaction at a time, tracked by grant edge and busy window
    int              edge_n = 0;
    int              next_free;
    int              g_edge;
    bit              g_owner;
    bit              g_read;
    bit              last_owner;
    bit              rst_active;
    bit              e_csb, e_wen;
    bit [1:0]        e_gnt, e_rv;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic [MASK_W-1:0] h_mask;
    logic [DATA_W-1:0] cur_rdata;
    logic [DATA_W-1:0] rdata_fix;
    bit              fix_en;

    int              gnt_log[$];
    int              last_m0_gnt = -1;
    int              last_m1_gnt = -1;
    int              t0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    task automatic apply_inputs();
        bus.m0_req_i   = req[0];
        bus.m0_wen_i   = wen[0];
        bus.m0_addr_i  = addr[0];
        bus.m0_data_i  = data[0];
        bus.m0_wmask_i = mask[0];
        bus.m1_req_i   = req[1];
        bus.m1_wen_i   = wen[1];
        bus.m1_addr_i  = addr[1];
        bus.m1_data_i  = data[1];
        bus.m1_wmask_i = mask[1];
    endtask

    task automatic issue(input int m, input bit w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] k);
        req[m]  = 1'b1;
        wen[m]  = w;
        addr[m] = a;
        data[m] = d;
        mask[m] = k;
        apply_inputs();
    endtask

    task automatic new_txn(input int m);
        req[m]  = 1'b1;
        wen[m]  = 1'($urandom_range(0, 1));
        addr[m] = $urandom;
        data[m] = $urandom;
        mask[m] = MASK_W'($urandom);
    endtask

    task automatic model_reset();
        e_csb      = 1'b1;
        e_wen      = 1'b1;
        e_gnt      = '0;
        e_rv       = '0;
        h_addr     = '0;
        h_data     = '0;
        h_mask     = '0;
        last_owner = 1'b1;
        g_edge     = -100;
        g_read     = 1'b0;
        next_free  = 0;
        for (int m = 0; m < 2; m++) req[m] = 1'b0;
        apply_inputs();
    endtask

    // Expected outputs after the current rising edge, from the inputs presented before it
    task automatic model_edge();
        bit w;
        bit tie;
        if (rst_active) return;
        e_csb = 1'b1;
        e_wen = 1'b1;
        e_gnt = '0;
        e_rv  = '0;
        if (g_read && edge_n == g_edge + 1) e_rv[g_owner] = 1'b1;
        if (edge_n >= next_free && (req[0] || req[1])) begin
`ifdef PARB_ROUND_ROBIN_EN
            tie = !last_owner;
`else
            tie = 1'b0;
`endif
            w          = (req[0] && req[1]) ? tie : req[1];
            g_edge     = edge_n;
            g_owner    = w;
            g_read     = wen[w];
            last_owner = w;
            h_addr     = addr[w];
            h_data     = data[w];
            h_mask     = mask[w];
            e_csb      = 1'b0;
            e_wen      = wen[w];
            e_gnt[w]   = 1'b1;
            next_free  = edge_n + (wen[w] ? 3 : 2);
        end
    endtask

    task automatic check_outputs();
        check_val("csb_o",       bus.csb_o,       e_csb);
        check_val("wen_o",       bus.wen_o,       e_wen);
        check_val("addr_o",      bus.addr_o,      h_addr);
        check_val("data_o",      bus.data_o,      h_data);
        check_val("wmask_o",     bus.wmask_o,     h_mask);
        check_val("m0_gnt_o",    bus.m0_gnt_o,    e_gnt[0]);
        check_val("m1_gnt_o",    bus.m1_gnt_o,    e_gnt[1]);
        check_val("m0_rvalid_o", bus.m0_rvalid_o, e_rv[0]);
        check_val("m1_rvalid_o", bus.m1_rvalid_o, e_rv[1]);
        check_val("m0_rdata_o",  bus.m0_rdata_o,  e_rv[0] ? cur_rdata : '0);
        check_val("m1_rdata_o",  bus.m1_rdata_o,  e_rv[1] ? cur_rdata : '0);
    endtask

    // One clock: model the edge, check, then let masters react (mode 0 none, 1 random, 2 saturate)
    task automatic step(input int mode);
        @(posedge clk_i);
        edge_n++;
        model_edge();
        #1;
        cur_rdata   = fix_en ? rdata_fix : DATA_W'($urandom);
        bus.rdata_i = cur_rdata;
        #1;
        check_outputs();
        if (!rst_active) begin
            if (bus.m0_gnt_o) begin gnt_log.push_back(0); last_m0_gnt = edge_n; end
            if (bus.m1_gnt_o) begin gnt_log.push_back(1); last_m1_gnt = edge_n; end
        end
        for (int m = 0; m < 2; m++) begin
            if (e_gnt[m]) req[m] = 1'b0;
            if (!req[m] && !rst_active) begin
                if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)) new_txn(m);
            end
        end
        apply_inputs();
    endtask

    task automatic assert_reset();
        reset_i    = 1'b0;
        rst_active = 1'b1;
        model_reset();
        #1;
        cur_rdata   = DATA_W'($urandom);
        bus.rdata_i = cur_rdata;
        check_outputs();
    endtask

    task automatic release_reset();
        reset_i    = 1'b1;
        rst_active = 1'b0;
        next_free  = edge_n + 1;
    endtask

    initial begin
        reset_i     = 1'b1;
        fix_en      = 1'b0;
        rdata_fix   = '0;
        cur_rdata   = '0;
        bus.rdata_i = '0;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; wen[m] = 1'b1; addr[m] = '0; data[m] = '0; mask[m] = '0;
        end
        apply_inputs();
        #1;
        assert_reset();
        repeat (2) step(0);
        release_reset();
        repeat (3) step(0);
        check_val("idle_csb", bus.csb_o, 1'b1);

        // Directed m0 write
        issue(0, 1'b0, 32'h8000_0010, 32'h0000_0001, 4'hF);
        step(0);
        check_val("wr_gnt",  bus.m0_gnt_o, 1'b1);
        check_val("wr_addr", bus.addr_o,   32'h8000_0010);
        check_val("wr_wen",  bus.wen_o,    1'b0);
        step(0);
        check_val("wr_csb_release", bus.csb_o, 1'b1);
        step(0);

        // Directed m1 read with fixed slave data
        fix_en    = 1'b1;
        rdata_fix = 32'hDEAD_BEEF;
        issue(1, 1'b1, 32'h8000_0020, 32'h0, 4'h0);
        step(0);
        check_val("rd_gnt", bus.m1_gnt_o, 1'b1);
        step(0);
        check_val("rd_rvalid",   bus.m1_rvalid_o, 1'b1);
        check_val("rd_rdata",    bus.m1_rdata_o,  32'hDEAD_BEEF);
        check_val("rd_m0_rdata", bus.m0_rdata_o,  32'h0);
        fix_en = 1'b0;
        repeat (2) step(0);

        // Both masters saturate the bus starting from a fresh reset
        assert_reset();
        step(0);
        release_reset();
        new_txn(0);
        new_txn(1);
        apply_inputs();
        gnt_log.delete();
        repeat (20) step(2);
        check_val("tie_count", 64'(gnt_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
`ifdef PARB_ROUND_ROBIN_EN
            check_val($sformatf("tie_gnt%0d", i), 64'(gnt_log[i]), 64'(i % 2));
`else
            check_val($sformatf("tie_gnt%0d", i), 64'(gnt_log[i]), 64'd0);
`endif
        end
        repeat (12) step(0);

        // m1 request arriving while an m0 read is in progress
        issue(0, 1'b1, 32'h8000_0030, 32'h0, 4'h0);
        step(0);
        t0 = edge_n;
        issue(1, 1'b0, 32'h8000_0040, 32'h1234_5678, 4'h3);
        repeat (4) step(0);
        check_val("m1_wait_slot", 64'(last_m1_gnt - t0), 64'd3);
        repeat (3) step(0);

        // Reset during an m0 read access drops the response
        issue(0, 1'b1, 32'h8000_0050, 32'h0, 4'h0);
        step(0);
        check_val("pre_rst_gnt", bus.m0_gnt_o, 1'b1);
        assert_reset();
        check_val("rst_csb", bus.csb_o, 1'b1);
        repeat (2) step(0);
        release_reset();
        step(0);
        check_val("no_rv_after_rst", bus.m0_rvalid_o, 1'b0);
        issue(1, 1'b0, 32'h8000_0060, 32'hCAFE_F00D, 4'h5);
        step(0);
        check_val("m1_after_rst", bus.m1_gnt_o, 1'b1);
        repeat (2) step(0);

        // Random traffic, then drain
        repeat (400) step(1);
        repeat (12) step(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
